uart_cmd_ctrl: RTL and testbench

Command sequencer between the receive UART and the board I/O on the iCEstick design. Consumes bytes from `uart_rx`, assembles fixed 4-byte command frames, validates them, and applies SET/TOGGLE/READ operations to an LED register. Every frame, or frame timeout, produces a 2-byte response through `uart_tx` via a start/busy handshake.

---
 rtl/uart_cmd_ctrl.sv | 152 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// Byte-stream command sequencer: assembles SYNC/CMD/ARG/CHK frames, drives the LED register, answers with a 2-byte ACK/NAK.
// Latency: EXEC one cycle after the CHK byte; leds and the first tx_start two cycles after it.
// Backpressure: each response byte waits for tx_busy low; bytes arriving while a frame executes or responds are dropped.
module uart_cmd_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_200_000,
    parameter int         NUM_LEDS       = 5
) (
    input  logic                clk,
    input  logic                rst,
    output logic                rx_enable,
    input  logic [7:0]          rx_byte,
    input  logic                byte_available,
    output logic [7:0]          tx_byte,
    output logic                tx_start,
    input  logic                tx_busy,
    output logic [NUM_LEDS-1:0] leds,
    output logic                frame_err
);
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] ST_ACK = 8'h06;
    localparam logic [7:0] ST_NAK = 8'h15;

    typedef enum logic [3:0] {
        IDLE, GET_CMD, GET_ARG, GET_CHK, EXEC,
        SEND_STAT, WAIT_STAT, SEND_DATA, WAIT_DATA
    } state_t;

    state_t              state;
    logic [7:0]          cmd;
    logic [7:0]          arg;
    logic [7:0]          chk;
    logic [7:0]          data_byte;
    logic [TW-1:0]       to_cnt;
    logic                skip;
    logic [NUM_LEDS-1:0] led_next;
    logic                cmd_ok;
    logic                chk_ok;

    assign cmd_ok = (cmd == 8'h01) || (cmd == 8'h02) || (cmd == 8'h03);
    assign chk_ok = (chk == (cmd ^ arg));

    always_comb begin
        led_next = leds;
        case (cmd)
            8'h01:   led_next = arg[NUM_LEDS-1:0];
            8'h02:   led_next = leds ^ arg[NUM_LEDS-1:0];
            default: led_next = leds;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rx_enable <= 1'b0;
            tx_byte   <= 8'h00;
            tx_start  <= 1'b0;
            leds      <= '0;
            frame_err <= 1'b0;
            cmd       <= 8'h00;
            arg       <= 8'h00;
            chk       <= 8'h00;
            data_byte <= 8'h00;
            to_cnt    <= '0;
            skip      <= 1'b0;
        end else begin
            rx_enable <= 1'b1;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (byte_available && rx_byte == SYNC_BYTE)
                        state <= GET_CMD;
                end
                GET_CMD, GET_ARG, GET_CHK: begin
                    // An arriving byte beats a timeout expiring in the same cycle.
                    if (byte_available) begin
                        to_cnt <= '0;
                        case (state)
                            GET_CMD: begin
                                cmd   <= rx_byte;
                                state <= GET_ARG;
                            end
                            GET_ARG: begin
                                arg   <= rx_byte;
                                state <= GET_CHK;
                            end
                            default: begin
                                chk <= rx_byte;
                                // Registered so the pulse lands in the EXEC cycle itself.
                                frame_err <= (rx_byte != (cmd ^ arg)) || !cmd_ok;
                                state     <= EXEC;
                            end
                        endcase
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt    <= '0;
                        tx_byte   <= ST_NAK;
                        data_byte <= 8'h03;
                        tx_start  <= !tx_busy;
                        frame_err <= 1'b1;
                        state     <= SEND_STAT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    if (!chk_ok) begin
                        tx_byte   <= ST_NAK;
                        data_byte <= 8'h01;
                    end else if (!cmd_ok) begin
                        tx_byte   <= ST_NAK;
                        data_byte <= 8'h02;
                    end else begin
                        leds      <= led_next;
                        tx_byte   <= ST_ACK;
                        data_byte <= 8'(led_next);
                    end
                    tx_start <= !tx_busy;
                    state    <= SEND_STAT;
                end
                SEND_STAT, SEND_DATA: begin
                    // tx_start is high for exactly one cycle of this state.
                    if (tx_start) begin
                        tx_start <= 1'b0;
                        skip     <= 1'b1;
                        state    <= (state == SEND_STAT) ? WAIT_STAT : WAIT_DATA;
                    end else if (!tx_busy) begin
                        tx_start <= 1'b1;
                    end
                end
                WAIT_STAT: begin
                    if (skip) begin
                        skip <= 1'b0;
                    end else if (!tx_busy) begin
                        tx_byte  <= data_byte;
                        tx_start <= 1'b1;
                        state    <= SEND_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (skip)
                        skip <= 1'b0;
                    else if (!tx_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frames plus randomized traffic against a frame-level reference model.
// A behavioural uart_tx answers tx_start with a tx_busy window of programmable length.
// Response bytes, leds, frame_err pulses and start timing are scored per transaction.
module tb_uart_cmd_ctrl;
    localparam int         TO   = 100;
    localparam int         NL   = 5;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_enable;
    logic [7:0]    rx_byte = 8'h00;
    logic          byte_available = 1'b0;
    logic [7:0]    tx_byte;
    logic          tx_start;
    logic          tx_busy = 1'b0;
    logic [NL-1:0] leds;
    logic          frame_err;

    uart_cmd_ctrl #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO), .NUM_LEDS(NL)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_enable      (rx_enable),
        .rx_byte        (rx_byte),
        .byte_available (byte_available),
        .tx_byte        (tx_byte),
        .tx_start       (tx_start),
        .tx_busy        (tx_busy),
        .leds           (leds),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [7:0]    exp_q[$];
    logic [7:0]    obs_q[$];
    int            exp_err  = 0;
    int            err_cnt  = 0;
    int            busy_len = 4;
    logic          hold_chk = 1'b0;
    logic [NL-1:0] m_leds   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Behavioural uart_tx: capture on tx_start, then hold tx_busy for busy_len cycles.
    initial begin
        logic [7:0] held;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                check("start_while_busy", 32'(tx_busy), 32'd0);
                held = tx_byte;
                obs_q.push_back(held);
                hold_chk = 1'b1;
                @(posedge clk); #1 tx_busy = 1'b1;
                repeat (busy_len) begin
                    @(negedge clk);
                    check("start_in_busy", 32'(tx_start), 32'd0);
                    if (hold_chk) check("tx_hold", 32'(tx_byte), 32'(held));
                end
                @(posedge clk); #1 tx_busy = 1'b0;
                @(negedge clk);
                check("start_gap", 32'(tx_start), 32'd0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) err_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 cycles");
        $fatal(1);
    end

    // Frame-level reference: returns the 2-byte response and updates the model LED register.
    function automatic void model_frame(input logic [7:0] cmd, input logic [7:0] arg,
                                        input logic [7:0] chk,
                                        output logic [7:0] st, output logic [7:0] dt);
        st = 8'h15;
        if (chk != (cmd ^ arg)) begin
            dt = 8'h01;
        end else if (cmd < 8'h01 || cmd > 8'h03) begin
            dt = 8'h02;
        end else begin
            if (cmd == 8'h01) m_leds = arg[NL-1:0];
            if (cmd == 8'h02) m_leds = m_leds ^ arg[NL-1:0];
            st = 8'h06;
            dt = 8'(m_leds);
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        @(posedge clk); #1;
        rx_byte = b;
        byte_available = 1'b1;
        @(posedge clk); #1;
        byte_available = 1'b0;
        rx_byte = 8'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_enable"}, 32'(rx_enable), 32'd0);
        check({tag, "_tx_start"},  32'(tx_start),  32'd0);
        check({tag, "_tx_byte"},   32'(tx_byte),   32'd0);
        check({tag, "_leds"},      32'(leds),      32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    // Returns in the first response cycle (CHK + 2), after checking EXEC/leds/start latency.
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] arg,
                              input logic [7:0] chk, input int gchk);
        logic [7:0] st;
        logic [7:0] dt;
        logic       nak;
        logic       bsy;
        model_frame(cmd, arg, chk, st, dt);
        nak = (st == 8'h15);
        exp_q.push_back(st);
        exp_q.push_back(dt);
        if (nak) exp_err++;
        send_byte(SYNC, $urandom_range(0, 3));
        send_byte(cmd, $urandom_range(0, 3));
        send_byte(arg, $urandom_range(0, 3));
        send_byte(chk, gchk);
        check("exec_frame_err", 32'(frame_err), 32'(nak));
        bsy = tx_busy;
        @(posedge clk); #1;
        check("leds_latency", 32'(leds), 32'(m_leds));
        check("start_latency", 32'(tx_start), 32'(!bsy));
        if (!bsy) check("stat_byte", 32'(tx_byte), 32'(st));
    endtask

    task automatic send_partial(input int n_extra);
        send_byte(SYNC, $urandom_range(0, 3));
        for (int i = 0; i < n_extra; i++) send_byte(8'($urandom), $urandom_range(0, 3));
        exp_q.push_back(8'h15);
        exp_q.push_back(8'h03);
        exp_err++;
    endtask

    task automatic finish_txn();
        int n = 0;
        while ((obs_q.size() < exp_q.size() || tx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("txn_done", 32'(n < 3000), 32'd1);
        repeat (4) @(negedge clk);
        check("txn_len", 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check("resp_byte", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        obs_q.delete();
        check("frame_err_count", 32'(err_cnt), 32'(exp_err));
        err_cnt = 0;
        exp_err = 0;
        check("leds", 32'(leds), 32'(m_leds));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        check("rx_enable_hold", 32'(rx_enable), 32'd0);
        @(posedge clk); #1;
        check("rx_enable_rise", 32'(rx_enable), 32'd1);

        send_frame(8'h01, 8'h15, 8'h14, 0);
        finish_txn();
        check("plan_set", 32'(leds), 32'b10101);
        send_frame(8'h02, 8'h03, 8'h01, 0);
        finish_txn();
        check("plan_toggle", 32'(leds), 32'b10110);
        send_frame(8'h01, 8'h1F, 8'h00, 0);
        finish_txn();
        send_frame(8'h07, 8'h00, 8'h07, 0);
        finish_txn();
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        finish_txn();
        send_partial(1);
        finish_txn();
        send_frame(8'h03, 8'h00, 8'h03, 0);
        finish_txn();

        // Byte on the expiry cycle is accepted; one cycle later the frame has timed out.
        send_frame(8'h01, 8'h0C, 8'h0D, TO - 2);
        finish_txn();
        check("boundary_accept", 32'(leds), 32'b01100);
        send_byte(SYNC, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        exp_q.push_back(8'h15);
        exp_q.push_back(8'h03);
        exp_err++;
        send_byte(8'h13, TO - 1);
        finish_txn();

        // Long busy with a stray SYNC injected while the status byte is in flight.
        busy_len = 50;
        send_frame(8'h02, 8'h1F, 8'h1D, 0);
        repeat (10) @(posedge clk);
        send_byte(SYNC, 0);
        finish_txn();
        busy_len = 3;
        send_frame(8'h03, 8'h00, 8'h03, 0);
        finish_txn();

        // Reset during a transmission; the next start must still wait for tx_busy low.
        busy_len = 50;
        send_frame(8'h01, 8'h0A, 8'h0B, 0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        hold_chk = 1'b0;
        #1;
        check_reset_vals("rst_tx");
        m_leds = '0;
        exp_q.delete();
        obs_q.delete();
        err_cnt = 0;
        exp_err = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rx_enable_hold2", 32'(rx_enable), 32'd0);
        @(posedge clk); #1;
        check("rx_enable_rise2", 32'(rx_enable), 32'd1);
        busy_len = 4;
        send_frame(8'h01, 8'h13, 8'h12, 0);
        finish_txn();

        // Reset mid-frame.
        send_byte(SYNC, 0);
        send_byte(8'h02, 0);
        rst = 1'b1;
        hold_chk = 1'b0;
        #1;
        check_reset_vals("rst_frame");
        m_leds = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(8'h02, 8'h05, 8'h07, 0);
        finish_txn();
        check("after_rst_frame", 32'(leds), 32'b00101);

        for (int t = 0; t < 40; t++) begin
            int         kind;
            logic [7:0] c;
            logic [7:0] a;
            logic [7:0] k;
            busy_len = $urandom_range(1, 8);
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                c = 8'($urandom);
                if (c == SYNC) c = 8'h5A;
                send_byte(c, $urandom_range(0, 3));
            end else if (kind == 1) begin
                send_partial($urandom_range(0, 2));
            end else begin
                c = 8'($urandom_range(0, 4));
                a = 8'($urandom);
                k = c ^ a;
                if ($urandom_range(0, 3) == 0) k = k ^ (8'h01 << $urandom_range(0, 7));
                send_frame(c, a, k, $urandom_range(0, 4));
            end
            finish_txn();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
